// File: rtl/dcache_pkg.sv
// Shared dcache constants: array geometry and data-path sequencer state encoding.
package dcache_pkg;
  localparam int D_INDEX_WIDTH = 6;
  localparam int D_WO_WIDTH    = 2;

  localparam logic [1:0] DC_IDLE  = 2'd0;
  localparam logic [1:0] DC_EVICT = 2'd1;
  localparam logic [1:0] DC_FILL  = 2'd2;
endpackage

// File: rtl/dcache_data_ctrl_if.sv
// Requester and ddram-side bus of the dcache data sequencer.
interface dcache_data_ctrl_if import dcache_pkg::*; #(
  parameter int IW = D_INDEX_WIDTH,
  parameter int OW = D_WO_WIDTH,
  parameter int DW = 32
) ();
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [IW-1:0] cpu_index;
  logic [OW-1:0] cpu_offset;
  logic [1:0]    cpu_way;
  logic [DW-1:0] cpu_wdata, cpu_rdata;

  logic          fill_req, fill_valid, fill_ready, fill_done;
  logic [IW-1:0] fill_index;
  logic [1:0]    fill_way;
  logic [DW-1:0] fill_data;

  logic          evict_req, evict_valid, evict_ready, evict_done;
  logic [IW-1:0] evict_index;
  logic [1:0]    evict_way;
  logic [DW-1:0] evict_data;

  logic [IW-1:0] ram_index;
  logic [OW-1:0] ram_offset;
  logic [1:0]    ram_way;
  logic [DW-1:0] ram_din, ram_dout0, ram_dout1, ram_dout2, ram_dout3;
  logic          ram_we, ram_en, busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_index, cpu_offset, cpu_way, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  fill_req, fill_index, fill_way, fill_data, fill_valid,
    output fill_ready, fill_done,
    input  evict_req, evict_index, evict_way, evict_ready,
    output evict_data, evict_valid, evict_done,
    output ram_index, ram_offset, ram_way, ram_din, ram_we, ram_en,
    input  ram_dout0, ram_dout1, ram_dout2, ram_dout3,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_index, cpu_offset, cpu_way, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output fill_req, fill_index, fill_way, fill_data, fill_valid,
    input  fill_ready, fill_done,
    output evict_req, evict_index, evict_way, evict_ready,
    input  evict_data, evict_valid, evict_done,
    input  ram_index, ram_offset, ram_way, ram_din, ram_we, ram_en,
    output ram_dout0, ram_dout1, ram_dout2, ram_dout3,
    input  busy
  );
endinterface

// File: rtl/dcache_data_ctrl_way_mux4.sv
// Per-way read-data select, shared by the CPU load and eviction paths.
module way_mux4 #(
  parameter int DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [DW-1:0] y
);
  always_comb begin
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end
endmodule

// File: rtl/dcache_data_ctrl.sv
// Arbitrates the single ddram port between eviction, refill and CPU word access
// (evict > fill > cpu) and sequences whole-line transfers word by word.
module dcache_data_ctrl import dcache_pkg::*; #(
  parameter int IW = D_INDEX_WIDTH,
  parameter int OW = D_WO_WIDTH,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  dcache_data_ctrl_if.slave  bus
);
  localparam logic [OW-1:0] LAST = '1;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    way_q, way_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d, fdone_q, fdone_d, edone_q, edone_d;

  logic [1:0]    mux_sel;
  logic [DW-1:0] mux_out;
  logic          gnt, fready, evalid, en, we;
  logic [IW-1:0] r_index;
  logic [OW-1:0] r_off;
  logic [1:0]    r_way;
  logic [DW-1:0] r_din;

  way_mux4 #(.DW(DW)) u_way_mux (
    .sel(mux_sel), .d0(bus.ram_dout0), .d1(bus.ram_dout1),
    .d2(bus.ram_dout2), .d3(bus.ram_dout3), .y(mux_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    way_d    = way_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    fdone_d  = 1'b0;
    edone_d  = 1'b0;
    mux_sel  = bus.cpu_way;
    gnt      = 1'b0;
    fready   = 1'b0;
    evalid   = 1'b0;
    en       = 1'b0;
    we       = 1'b0;
    r_index  = '0;
    r_off    = '0;
    r_way    = '0;
    r_din    = '0;
    case (state_q)
      DC_IDLE: begin
        if (bus.evict_req) begin
          state_d = DC_EVICT;
          idx_d   = bus.evict_index;
          way_d   = bus.evict_way;
          cnt_d   = '0;
        end else if (bus.fill_req) begin
          state_d = DC_FILL;
          idx_d   = bus.fill_index;
          way_d   = bus.fill_way;
          cnt_d   = '0;
        end else if (bus.cpu_req) begin
          gnt     = 1'b1;
          en      = 1'b1;
          we      = bus.cpu_we;
          r_index = bus.cpu_index;
          r_off   = bus.cpu_offset;
          r_way   = bus.cpu_way;
          r_din   = bus.cpu_wdata;
          if (!bus.cpu_we) begin
            rdata_d  = mux_out;
            rvalid_d = 1'b1;
          end
        end
      end
      DC_EVICT: begin
        mux_sel = way_q;
        evalid  = 1'b1;
        en      = 1'b1;
        r_index = idx_q;
        r_off   = cnt_q;
        r_way   = way_q;
        if (bus.evict_ready) begin
          if (cnt_q == LAST) begin
            state_d = DC_IDLE;
            edone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DC_FILL: begin
        fready = 1'b1;
        if (bus.fill_valid) begin
          en      = 1'b1;
          we      = 1'b1;
          r_index = idx_q;
          r_off   = cnt_q;
          r_way   = way_q;
          r_din   = bus.fill_data;
          if (cnt_q == LAST) begin
            state_d = DC_IDLE;
            fdone_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DC_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      way_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      edone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      way_q    <= way_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      fdone_q  <= fdone_d;
      edone_q  <= edone_d;
    end
  end

  // evict_data is forced to zero outside the eviction stream
  assign bus.cpu_gnt     = gnt;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_rvalid  = rvalid_q;
  assign bus.fill_ready  = fready;
  assign bus.fill_done   = fdone_q;
  assign bus.evict_valid = evalid;
  assign bus.evict_data  = evalid ? mux_out : '0;
  assign bus.evict_done  = edone_q;
  assign bus.ram_en      = en;
  assign bus.ram_we      = we;
  assign bus.ram_index   = r_index;
  assign bus.ram_offset  = r_off;
  assign bus.ram_way     = r_way;
  assign bus.ram_din     = r_din;
  assign bus.busy        = (state_q != DC_IDLE);
endmodule

// File: tb/tb_dcache_data_ctrl.sv
// Self-checking bench: behavioural ddram plus a line-content reference model.
module tb_dcache_data_ctrl;
  import dcache_pkg::*;
  localparam int IW = D_INDEX_WIDTH;
  localparam int OW = D_WO_WIDTH;
  localparam int DW = 32;
  localparam int L  = 1 << OW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_data_ctrl_if #(.IW(IW), .OW(OW), .DW(DW)) bus ();
  dcache_data_ctrl #(.IW(IW), .OW(OW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] ram     [4][1<<IW][L];
  logic [DW-1:0] ref_mem [4][1<<IW][L];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk)
    if (bus.ram_en && bus.ram_we) ram[bus.ram_way][bus.ram_index][bus.ram_offset] <= bus.ram_din;
  assign bus.ram_dout0 = ram[0][bus.ram_index][bus.ram_offset];
  assign bus.ram_dout1 = ram[1][bus.ram_index][bus.ram_offset];
  assign bus.ram_dout2 = ram[2][bus.ram_index][bus.ram_offset];
  assign bus.ram_dout3 = ram[3][bus.ram_index][bus.ram_offset];

  task automatic cyc();    @(posedge clk); #1; endtask
  task automatic settle(); #2;             endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_index = '0; bus.cpu_offset = '0;
    bus.cpu_way = '0; bus.cpu_wdata = '0;
    bus.fill_req = 0; bus.fill_index = '0; bus.fill_way = '0; bus.fill_data = '0; bus.fill_valid = 0;
    bus.evict_req = 0; bus.evict_index = '0; bus.evict_way = '0; bus.evict_ready = 0;
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    idle_inputs(); rst_n = 0;
    cyc(); cyc(); settle();
    flags = {bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid,
             bus.evict_done, bus.ram_we, bus.ram_en, bus.busy};
    n_cmp++; if (flags !== '0) begin n_err++; $display("FAIL reset_flags: got %b want 0", flags); end
    n_cmp++; if (bus.cpu_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); end
    rst_n = 1;
  endtask

  task automatic test_store_load();
    logic [2:0] f;
    cyc(); bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_index = IW'(5); bus.cpu_offset = OW'(2);
    bus.cpu_way = 2'd3; bus.cpu_wdata = 32'hDEADBEEF; settle();
    ref_mem[3][5][2] = 32'hDEADBEEF;
    f = {bus.cpu_gnt, bus.ram_en, bus.ram_we};
    n_cmp++; if (f !== 3'b111) begin n_err++; $display("FAIL store_gnt: got %b want 111", f); end
    cyc(); bus.cpu_we = 0; settle();
    f = {bus.cpu_gnt, bus.ram_en, bus.ram_we};
    n_cmp++; if (f !== 3'b110) begin n_err++; $display("FAIL load_gnt: got %b want 110", f); end
    cyc(); bus.cpu_req = 0; settle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL load_data: got v=%b %h want v=1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
    cyc(); settle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse: got %b want 0", bus.cpu_rvalid); end
  endtask

  task automatic test_back_to_back();
    bit pend; logic [DW-1:0] pend_d; int ix, wy, of;
    for (int i = 0; i < 2 * 4 * L; i++) begin
      cyc(); bus.cpu_req = 1; bus.cpu_we = 1; ix = i / (4 * L); wy = (i / L) % 4; of = i % L;
      bus.cpu_index = IW'(ix); bus.cpu_way = 2'(wy); bus.cpu_offset = OW'(of);
      bus.cpu_wdata = $urandom; ref_mem[wy][ix][of] = bus.cpu_wdata; settle();
      n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_err++; $display("FAIL prefill_gnt %0d: got %b want 1", i, bus.cpu_gnt); end
    end
    pend = 0; pend_d = '0;
    for (int k = 0; k <= 60; k++) begin
      cyc();
      bus.cpu_req = (k < 60) && ($urandom % 4 != 0); bus.cpu_we = 1'($urandom);
      ix = $urandom % 2; wy = $urandom % 4; of = $urandom % L;
      bus.cpu_index = IW'(ix); bus.cpu_way = 2'(wy); bus.cpu_offset = OW'(of); bus.cpu_wdata = $urandom;
      settle();
      n_cmp++; if (bus.cpu_gnt !== bus.cpu_req) begin n_err++; $display("FAIL b2b_gnt %0d: got %b want %b", k, bus.cpu_gnt, bus.cpu_req); end
      n_cmp++; if (bus.cpu_rvalid !== pend || (pend && bus.cpu_rdata !== pend_d)) begin
        n_err++; $display("FAIL b2b_rdata %0d: got v=%b %h want v=%b %h", k, bus.cpu_rvalid, bus.cpu_rdata, pend, pend_d); end
      pend = bus.cpu_req && !bus.cpu_we;
      pend_d = ref_mem[wy][ix][of];
      if (bus.cpu_req && bus.cpu_we) ref_mem[wy][ix][of] = bus.cpu_wdata;
    end
    bus.cpu_req = 0;
  endtask

  task automatic test_fill_gaps();
    int word, we_cnt; bit fin, hs;
    word = 0; we_cnt = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      cyc();
      bus.fill_req = (word < L); bus.fill_index = IW'(9); bus.fill_way = 2'd1;
      bus.fill_valid = (c % 2 == 1) && (word < L); bus.fill_data = 32'hA0 + word;
      settle();
      n_cmp++; if (bus.fill_done !== (word == L)) begin n_err++; $display("FAIL fill_done c%0d: got %b want %b", c, bus.fill_done, word == L); end
      if (word == L) fin = 1;
      else begin
        hs = bus.fill_ready && bus.fill_valid;
        n_cmp++; if (bus.ram_we !== hs) begin n_err++; $display("FAIL fill_we c%0d: got %b want %b", c, bus.ram_we, hs); end
        if (bus.ram_we) we_cnt++;
        if (hs) begin
          n_cmp++; if (bus.ram_offset !== OW'(word) || bus.ram_index !== IW'(9) || bus.ram_way !== 2'd1) begin
            n_err++; $display("FAIL fill_addr w%0d: got %0d/%0d/%0d want 9/%0d/1", word, bus.ram_index, bus.ram_offset, bus.ram_way, word); end
          ref_mem[1][9][word] = 32'hA0 + word; word++;
        end
      end
    end
    bus.fill_valid = 0; bus.fill_req = 0;
    n_cmp++; if (we_cnt !== L || !fin) begin n_err++; $display("FAIL fill_count: got %0d fin=%b want %0d fin=1", we_cnt, fin, L); end
    for (int o = 0; o <= L; o++) begin
      cyc(); bus.cpu_req = (o < L); bus.cpu_we = 0; bus.cpu_index = IW'(9); bus.cpu_way = 2'd1; bus.cpu_offset = OW'(o);
      settle();
      if (o == 0) begin
        n_cmp++; if (bus.fill_done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL fill_post: got done=%b busy=%b want 0 0", bus.fill_done, bus.busy); end
      end else begin
        n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== ref_mem[1][9][o-1]) begin
          n_err++; $display("FAIL fill_readback o%0d: got %h want %h", o - 1, bus.cpu_rdata, ref_mem[1][9][o-1]); end
      end
    end
    bus.cpu_req = 0;
  endtask

  task automatic test_evict_stall();
    int word, stall; bit fin; logic [2:0] f;
    word = 0; stall = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      cyc();
      bus.evict_req = (word < L); bus.evict_index = IW'(9); bus.evict_way = 2'd1;
      bus.evict_ready = !(word == 1 && stall < 3);
      settle();
      n_cmp++; if (bus.evict_done !== (word == L)) begin n_err++; $display("FAIL evict_done c%0d: got %b want %b", c, bus.evict_done, word == L); end
      if (word == L) fin = 1;
      else begin
        f = {bus.evict_valid, bus.ram_en, bus.ram_we};
        n_cmp++; if (f !== ((c > 0) ? 3'b110 : 3'b000)) begin n_err++; $display("FAIL evict_ctl c%0d: got %b", c, f); end
        if (bus.evict_valid) begin
          n_cmp++; if (bus.evict_data !== ref_mem[1][9][word]) begin
            n_err++; $display("FAIL evict_data w%0d: got %h want %h", word, bus.evict_data, ref_mem[1][9][word]); end
          if (bus.evict_ready) word++; else stall++;
        end
      end
    end
    bus.evict_req = 0;
    cyc(); settle();
    n_cmp++; if (bus.evict_done !== 1'b0 || stall !== 3 || !fin) begin
      n_err++; $display("FAIL evict_once: got done=%b stall=%0d fin=%b want 0 3 1", bus.evict_done, stall, fin); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] fd [L]; int fw, ew; logic [4:0] got, exp;
    for (int i = 0; i < L; i++) fd[i] = $urandom;
    fw = 0; ew = 0;
    for (int c = 0; c <= 11; c++) begin
      cyc();
      bus.evict_req = (c < 5); bus.evict_index = IW'(9); bus.evict_way = 2'd1; bus.evict_ready = 1;
      bus.fill_req = (c < 10); bus.fill_index = IW'(12); bus.fill_way = 2'd2; bus.fill_valid = 1;
      bus.fill_data = fd[fw % L];
      bus.cpu_req = (c <= 10); bus.cpu_we = 0; bus.cpu_index = IW'(12); bus.cpu_way = 2'd2; bus.cpu_offset = '0;
      settle();
      got = {bus.evict_valid, bus.evict_done, bus.fill_ready, bus.fill_done, bus.cpu_gnt};
      exp = {c >= 1 && c <= 4, c == 5, c >= 6 && c <= 9, c == 10, c == 10};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_seq c%0d: got %b want %b", c, got, exp); end
      if (bus.evict_valid) begin
        n_cmp++; if (bus.evict_data !== ref_mem[1][9][ew]) begin n_err++; $display("FAIL simul_evict w%0d: got %h want %h", ew, bus.evict_data, ref_mem[1][9][ew]); end
        ew++;
      end
      if (bus.fill_ready && bus.fill_valid && fw < L) begin ref_mem[2][12][fw] = fd[fw]; fw++; end
      if (c == 11) begin
        n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== fd[0]) begin
          n_err++; $display("FAIL simul_load: got v=%b %h want v=1 %h", bus.cpu_rvalid, bus.cpu_rdata, fd[0]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    logic [9:0] flags; int w;
    w = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(); bus.fill_req = 1; bus.fill_index = IW'(20); bus.fill_way = 2'd0; bus.fill_valid = 1;
      bus.fill_data = $urandom; settle();
      if (bus.fill_ready && bus.fill_valid) begin ref_mem[0][20][w] = bus.fill_data; w++; end
    end
    n_cmp++; if (bus.busy !== 1'b1 || w !== 2) begin n_err++; $display("FAIL midfill_busy: got busy=%b words=%0d want 1 2", bus.busy, w); end
    cyc(); rst_n = 0; bus.fill_req = 0; bus.fill_valid = 0;
    cyc(); settle();
    flags = {bus.cpu_gnt, bus.cpu_rvalid, bus.fill_ready, bus.fill_done, bus.evict_valid,
             bus.evict_done, bus.ram_we, bus.ram_en, bus.busy, |bus.cpu_rdata};
    n_cmp++; if (flags !== '0) begin n_err++; $display("FAIL midfill_reset: got %b want 0", flags); end
    rst_n = 1;
    for (int o = 0; o <= 2; o++) begin
      cyc(); bus.cpu_req = (o < 2); bus.cpu_we = 0; bus.cpu_index = IW'(20); bus.cpu_way = 2'd0; bus.cpu_offset = OW'(o);
      settle();
      n_cmp++; if (bus.fill_done !== 1'b0) begin n_err++; $display("FAIL midfill_nodone o%0d: got %b want 0", o, bus.fill_done); end
      if (o > 0) begin
        n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== ref_mem[0][20][o-1]) begin
          n_err++; $display("FAIL midfill_kept o%0d: got %h want %h", o - 1, bus.cpu_rdata, ref_mem[0][20][o-1]); end
      end
    end
    bus.cpu_req = 0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_fill_gaps();
    test_evict_stall();
    test_simultaneous();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_data_ctrl.md
# dcache_data_ctrl

Sequencer and arbiter for the data-cache data array (the four-way `ddram`). It shares the array's single index/offset port between three requesters: CPU word loads/stores, line refill from memory, and dirty-line eviction to the write buffer. It sits between the dcache tag/miss logic and `ddram`, and owns every `ddram` control input.

## Interface
- `IW`, default `D_INDEX_WIDTH`: set-index width.
- `OW`, default `D_WO_WIDTH`: word-offset width; a line holds 2^OW words.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1: single clock. The `ddram` array writes on the negedge of this clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `cpu_req`  in  1: CPU word access request. Level; held until granted.
- `cpu_we`  in  1: CPU access is a store.
- `cpu_index`  in  IW; `cpu_offset`  in  OW; `cpu_way`  in  2: CPU target location.
- `cpu_wdata`  in  DW: store data.
- `cpu_gnt`  out  1: access performed this cycle (combinational).
- `cpu_rdata`  out  DW: registered load data.
- `cpu_rvalid`  out  1: one-cycle pulse, the cycle after a granted load.
- `fill_req`  in  1: refill request. Level; held until `fill_done`. `fill_index`, `fill_way` are stable while held.
- `fill_index`  in  IW; `fill_way`  in  2: refill target.
- `fill_data`  in  DW; `fill_valid`  in  1: refill word stream, in offset order starting at 0.
- `fill_ready`  out  1: refill word accepted when high together with `fill_valid`.
- `fill_done`  out  1: one-cycle pulse, registered.
- `evict_req`  in  1; `evict_index`  in  IW; `evict_way`  in  2: eviction request. Same holding rules as refill.
- `evict_data`  out  DW; `evict_valid`  out  1; `evict_ready`  in  1: eviction word stream, offset order.
- `evict_done`  out  1: one-cycle pulse, registered.
- `ram_index`  out  IW; `ram_offset`  out  OW; `ram_way`  out  2; `ram_din`  out  DW; `ram_we`  out  1; `ram_en`  out  1: `ddram` controls.
- `ram_dout0`..`ram_dout3`  in  DW each: `ddram` per-way combinational read data.
- `busy`  out  1: state ≠ IDLE.

## Operation
- FSM states: IDLE, EVICT, FILL.
- IDLE arbitration, fixed priority evict > fill > cpu:
  - `evict_req` → EVICT.
  - Otherwise `fill_req` → FILL.
  - Otherwise `cpu_req` → `cpu_gnt`=1 and the access is driven to RAM this cycle.
  - On entry to EVICT or FILL: latch index and way; set word counter `cnt` to 0.
- CPU access in IDLE:
  - `ram_en`=1; RAM address = cpu index/offset/way; `ram_we`=`cpu_we`; `ram_din`=`cpu_wdata`.
  - Load: `cpu_rdata` ← `ram_dout[cpu_way]` at the clock edge; `cpu_rvalid`=1 the next cycle.
- No `cpu_gnt` in EVICT/FILL, and none in an IDLE cycle where `evict_req` or `fill_req` is high.
- EVICT:
  - `ram_en`=1, `ram_we`=0, address = latched index, `cnt`, latched way.
  - `evict_data` = `ram_dout[way]` (combinational); `evict_valid`=1.
  - On `evict_ready`: `cnt`++.
  - On the handshake with `cnt`=2^OW−1: go to IDLE and pulse `evict_done` the next cycle.
- FILL:
  - `fill_ready`=1.
  - On `fill_valid`: `ram_en`=`ram_we`=1, `ram_din`=`fill_data`, address = latched index, `cnt`, latched way; `cnt`++.
  - Last word (`cnt`=2^OW−1): go to IDLE and pulse `fill_done`.
- `cnt` is OW bits, compared for the last word and never wraps inside a transaction; it is cleared on entry.
- Requester must drop its `*_req` in the `*_done` cycle. If a request is still high in IDLE after its done pulse, it is treated as a new transaction.
- Undriven RAM fields are 0 when `ram_en`=0.

## Timing
- Reset: state IDLE, `cnt`=0, and these outputs are 0: `cpu_gnt`, `cpu_rvalid`, `cpu_rdata`, `fill_ready`, `fill_done`, `evict_valid`, `evict_done`, `ram_we`, `ram_en`, `busy`.
- Reset mid-transaction: abandon it with no done pulse. A partially filled line is left as written.
- CPU load latency: grant cycle N → `cpu_rvalid`/`cpu_rdata` at N+1. A store completes at the negedge of cycle N.
- Back-to-back CPU accesses: one per cycle.
- Fill with continuous `fill_valid`: 2^OW cycles in FILL. `fill_done` is high the cycle after the last word, and the FSM is already in IDLE, so a CPU grant is possible in that cycle.
- Evict with continuous `evict_ready`: 2^OW cycles, then `evict_done`.
- Fill and evict requested in the same cycle: evict runs first; fill starts in the IDLE cycle after `evict_done`.

## Structure
- Shared package `dcache_pkg`:
  - FSM state encoding `DC_IDLE`/`DC_EVICT`/`DC_FILL`.
  - Width constants tied to `D_INDEX_WIDTH`/`D_WO_WIDTH`.
- One natural sub-module: `way_mux4`, selecting `ram_dout0..3` by a 2-bit way. It is used for both the CPU load and evict paths.

## Test plan
- Store then load, after reset (OW=2): store `cpu_index`=5, `cpu_offset`=2, `cpu_way`=3, `cpu_wdata`=0xDEADBEEF, then load the same location → `cpu_gnt` both cycles; `cpu_rvalid` one cycle after the load with `cpu_rdata`=0xDEADBEEF.
- Refill with gaps: `fill_req` to index 9, way 1, with `fill_valid` low every other cycle, words 0xA0..0xA3 → exactly 4 `ram_we` pulses at offsets 0..3; `fill_done` one cycle after the 4th word; CPU loads of offsets 0..3 return 0xA0..0xA3.
- Stalled eviction: evict the line from the refill test with `evict_ready` low for 3 cycles at word 1 → `evict_data` holds 0xA1 while stalled; sequence is 0xA0..0xA3; one `evict_done`.
- Simultaneous requests: `evict_req`, `fill_req` and `cpu_req` all high in one cycle → EVICT first, then FILL, then the CPU grant; `cpu_gnt` stays low until both done pulses have occurred.
- Reset mid-fill: `rst_n` low after 2 fill words → the next cycle shows IDLE with all outputs at reset values, no `fill_done`, and `busy`=0.
